proc_cmd_driver: RTL and testbench

//  Initiator for the 4-bit processor command interface. Buffers host operations,

---
 rtl/proc_drv_pkg.sv | 34 +++
 rtl/proc_cmd_fifo.sv | 56 +++++
 rtl/proc_cmd_driver.sv | 215 +++++++++++++++++++++
 tb/tb_proc_cmd_driver.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_drv_pkg.sv
// Shared types for the processor command driver: command word layout,
// FSM state encoding and interface widths.
package proc_drv_pkg;

    localparam int DATA_W   = 4;
    localparam int OP_W     = 3;
    localparam int ERRCNT_W = 8;

    typedef struct packed {
        logic              clr;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR1,
        ST_LDA,
        ST_GAPA,
        ST_LDB,
        ST_GAPB,
        ST_RUN,
        ST_CAPT,
        ST_RESP
    } state_t;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/proc_cmd_fifo.sv
// Synchronous command FIFO with a head-of-queue read port so the driver can
// inspect and pop the next command in the same cycle.
module proc_cmd_fifo
    import proc_drv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         push_ok;
    logic         pop_ok;

    // A push on a full FIFO is legal when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/proc_cmd_driver.sv
// Buffers host commands and drives the LOAD/LOAD/COMP (or CLR) sequence on the
// processor, returning R0/R1/ERR as a result token. Define PROC_DRV_ERRCNT_EN
// to enable the saturating err_count register (otherwise err_count is 0).
module proc_cmd_driver
    import proc_drv_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int COMP_CYCLES = 12,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_clr,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_r0,
    output logic [DATA_W-1:0]   res_r1,
    output logic                res_err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [DATA_W-1:0]   DATA,
    output logic                LOAD,
    output logic                COMP,
    output logic                CLR,
    output logic [OP_W-1:0]     OP,
    input  logic [DATA_W-1:0]   R0,
    input  logic [DATA_W-1:0]   R1,
    input  logic                ERR
);

    localparam int CNT_MAX = max2(COMP_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [OP_W-1:0]     op_reg, op_next;
    logic [DATA_W-1:0]   a_reg, a_next;
    logic [DATA_W-1:0]   b_reg, b_next;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   res_r0_reg, res_r0_next;
    logic [DATA_W-1:0]   res_r1_reg, res_r1_next;
    logic                res_err_reg, res_err_next;
    logic                ready_en_reg;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    cmd_t                fifo_din;
    cmd_t                fifo_dout;

    assign fifo_din  = '{clr: cmd_clr, op: cmd_op, a: cmd_a, b: cmd_b};
    // Held low through reset and for the release edge itself.
    assign cmd_ready = ready_en_reg && (!fifo_full || fifo_pop);
    assign fifo_push = cmd_valid && cmd_ready;

    proc_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            err_reg      <= 1'b0;
            res_r0_reg   <= '0;
            res_r1_reg   <= '0;
            res_err_reg  <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            err_reg      <= err_next;
            res_r0_reg   <= res_r0_next;
            res_r1_reg   <= res_r1_next;
            res_err_reg  <= res_err_next;
            ready_en_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        op_next      = op_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        err_next     = err_reg;
        res_r0_next  = res_r0_reg;
        res_r1_next  = res_r1_reg;
        res_err_next = res_err_reg;
        fifo_pop     = 1'b0;
        DATA         = '0;
        LOAD         = 1'b0;
        COMP         = 1'b0;
        CLR          = 1'b0;
        OP           = '0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    op_next    = fifo_dout.op;
                    a_next     = fifo_dout.a;
                    b_next     = fifo_dout.b;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = fifo_dout.clr ? ST_CLR1 : ST_LDA;
                end
            end
            ST_CLR1: begin
                CLR        = 1'b1;
                state_next = ST_IDLE;
            end
            ST_LDA: begin
                DATA       = a_reg;
                LOAD       = 1'b1;
                OP         = op_reg;
                state_next = (GAP_CYCLES > 0) ? ST_GAPA : ST_LDB;
            end
            ST_GAPA: begin
                OP = op_reg;
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_LDB;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_LDB: begin
                DATA       = b_reg;
                LOAD       = 1'b1;
                OP         = op_reg;
                state_next = (GAP_CYCLES > 0) ? ST_GAPB : ST_RUN;
            end
            ST_GAPB: begin
                OP = op_reg;
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                COMP     = 1'b1;
                OP       = op_reg;
                err_next = err_reg | ERR;
                if (cnt_reg == COMP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_CAPT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CAPT: begin
                res_r0_next  = R0;
                res_r1_next  = R1;
                res_err_next = err_reg;
                state_next   = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign res_valid = (state_reg == ST_RESP);
    assign res_r0    = res_r0_reg;
    assign res_r1    = res_r1_reg;
    assign res_err   = res_err_reg;

`ifdef PROC_DRV_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count_reg <= '0;
        end else if (res_valid && res_ready && res_err_reg && (err_count_reg != '1)) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_proc_cmd_driver.sv
// Scoreboard bench for proc_cmd_driver: a behavioural processor model answers
// the drive sequence, a monitor pops expected result tokens on each handshake.
module tb_proc_cmd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_clr = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_r0, res_r1;
    logic       res_err;
    logic [7:0] err_count;
    logic [3:0] DATA;
    logic       LOAD, COMP, CLR;
    logic [2:0] OP;
    logic [3:0] R0 = '0;
    logic [3:0] R1 = '0;
    logic       ERR = 1'b0;

    always #5 clk = ~clk;

    proc_cmd_driver #(
        .FIFO_DEPTH  (4),
        .COMP_CYCLES (12),
        .GAP_CYCLES  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clr   (cmd_clr),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_r0    (res_r0),
        .res_r1    (res_r1),
        .res_err   (res_err),
        .err_count (err_count),
        .DATA      (DATA),
        .LOAD      (LOAD),
        .COMP      (COMP),
        .CLR       (CLR),
        .OP        (OP),
        .R0        (R0),
        .R1        (R1),
        .ERR       (ERR)
    );

    typedef struct {
        logic       clr;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       inj;
        int         k;
    } tcmd_t;

    typedef struct {
        logic [3:0] r0;
        logic [3:0] r1;
        logic       err;
    } tres_t;

    tcmd_t drv_q[$];
    tres_t res_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ready_pct = 100;
    int    exp_errcnt = 0;

    // Processor function seen by the bench: R0 = a + b*(op+1), R1 = a - b (mod 16).
    function automatic logic [3:0] calc_r0(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [3:0] m;
        m = {1'b0, op} + 4'd1;
        return a + b * m;
    endfunction

    function automatic tcmd_t mk(input logic clr, input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic inj, input int k);
        tcmd_t c;
        c.clr = clr; c.op = op; c.a = a; c.b = b; c.inj = inj; c.k = k;
        return c;
    endfunction

    function automatic tcmd_t rnd_cmd(input int clr_pct);
        return mk(($urandom_range(0, 99) < clr_pct), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 35), $urandom_range(0, 11));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input tcmd_t c);
        int    g;
        tres_t r;
        g = 0;
        cmd_valid = 1'b1; cmd_clr = c.clr; cmd_op = c.op; cmd_a = c.a; cmd_b = c.b;
        while (!cmd_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=%0d cycles required=<2000", g);
        end else begin
            drv_q.push_back(c);
            if (!c.clr) begin
                r.r0 = calc_r0(c.a, c.b, c.op); r.r1 = c.a - c.b; r.err = c.inj;
                res_q.push_back(r);
            end
            $display("send clr=%0d op=%0d a=%0d b=%0d inj=%0d k=%0d", c.clr, c.op, c.a, c.b, c.inj, c.k);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((res_q.size() > 0 || drv_q.size() > 0 || res_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending results required=0", res_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Behavioural processor: observes the drive sequence and answers it.
    logic [3:0] ra = '0, rb = '0;
    int         ld_idx = 0, comp_len = 0;
    logic       active = 1'b0;
    tcmd_t      cur;

    always @(negedge clk) begin
        if (!rst) begin
            ld_idx = 0; comp_len = 0; active = 1'b0; ERR = 1'b0;
        end else begin
            ERR = 1'b0;
            chk("excl_load_comp_clr", 32'(LOAD) + 32'(COMP) + 32'(CLR) <= 1, 1);
            if (!LOAD) chk("data_zero_idle", DATA, 0);
            if (CLR) begin
                if (drv_q.size() == 0) chk("clr_unexpected", 1, 0);
                else begin
                    cur = drv_q.pop_front();
                    chk("clr_kind", cur.clr, 1);
                end
            end
            if (LOAD) begin
                if (ld_idx == 0) begin
                    if (drv_q.size() == 0) chk("load_unexpected", 1, 0);
                    else begin
                        cur = drv_q.pop_front();
                        chk("load_kind", cur.clr, 0);
                        chk("data_a", DATA, cur.a);
                    end
                    ra = DATA; ld_idx = 1; active = 1'b1;
                end else begin
                    chk("data_b", DATA, cur.b);
                    rb = DATA; ld_idx = 0;
                end
                if ($urandom_range(0, 3) == 0) ERR = 1'b1;
            end
            if (COMP) begin
                if (cur.inj && comp_len == cur.k) ERR = 1'b1;
                R0 = calc_r0(ra, rb, OP);
                R1 = ra - rb;
                comp_len++;
            end else if (comp_len > 0) begin
                chk("comp_len", comp_len, 12);
                comp_len = 0; active = 1'b0;
                if ($urandom_range(0, 2) == 0) ERR = 1'b1;
            end
            if (active) chk("op_hold", OP, cur.op);
        end
    end

    // Result monitor: handshake compare, RESP stability and quiet processor side.
    logic  hold = 1'b0;
    tres_t held;
    tres_t e;

    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0; res_ready = 1'b0;
        end else begin
            if (hold) begin
                chk("resp_valid_hold", res_valid, 1);
                chk("resp_r0_stable", res_r0, held.r0);
                chk("resp_r1_stable", res_r1, held.r1);
                chk("resp_err_stable", res_err, held.err);
            end
            res_ready = ($urandom_range(0, 99) < ready_pct);
            if (res_valid) begin
                chk("resp_quiet", LOAD | COMP | CLR, 0);
                if (res_ready) begin
                    if (res_q.size() == 0) chk("result_unexpected", 1, 0);
                    else begin
                        e = res_q.pop_front();
                        $display("result r0=%0d r1=%0d err=%0d", res_r0, res_r1, res_err);
                        chk("res_r0", res_r0, e.r0);
                        chk("res_r1", res_r1, e.r1);
                        chk("res_err", res_err, e.err);
`ifdef PROC_DRV_ERRCNT_EN
                        if (e.err && exp_errcnt < 255) exp_errcnt++;
`endif
                    end
                end
            end
            hold = res_valid && !res_ready;
            held.r0 = res_r0; held.r1 = res_r1; held.err = res_err;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_ctrl"}, {LOAD, COMP, CLR}, 0);
        chk({tag, "_data_op"}, {DATA, OP}, 0);
        chk({tag, "_res_regs"}, {res_r0, res_r1, res_err}, 0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", cmd_ready, 1);

        // Single command latency and drive sequence.
        ready_pct = 100;
        send(mk(1'b0, 3'b010, 4'd3, 4'd5, 1'b0, 0));
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 18);
        drain();

        // ERR pulse inside the COMP window, including both window edges.
        send(mk(1'b0, 3'd1, 4'd9, 4'd4, 1'b1, 5));
        send(mk(1'b0, 3'd6, 4'd2, 4'd7, 1'b1, 0));
        send(mk(1'b0, 3'd7, 4'd15, 4'd1, 1'b1, 11));
        drain();
        chk("err_count_after_err", err_count, exp_errcnt);

        // Clear command, then a normal command from IDLE.
        send(mk(1'b1, 3'd0, 4'd0, 4'd0, 1'b0, 0));
        send(mk(1'b0, 3'd7, 4'd15, 4'd15, 1'b0, 0));
        drain();

        // Fill the FIFO with results blocked; ready must drop.
        ready_pct = 0;
        for (int i = 0; i < 5; i++) send(rnd_cmd(0));
        repeat (2) @(negedge clk);
        chk("ready_full", cmd_ready, 0);
        ready_pct = 100;
        send(rnd_cmd(0));
        drain();

        // Long stall in RESP with a command waiting behind it.
        ready_pct = 0;
        send(rnd_cmd(0));
        send(rnd_cmd(0));
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_res_valid", res_valid, 1);
        repeat (10) @(negedge clk);
        ready_pct = 100;
        drain();

        // Reset in the middle of RUN with commands still buffered.
        send(rnd_cmd(0));
        send(rnd_cmd(0));
        send(rnd_cmd(0));
        n = 0;
        while (!COMP && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrun");
        res_q.delete();
        drv_q.delete();
        exp_errcnt = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_midrun", cmd_ready, 1);
        chk("no_result_after_reset", res_valid, 0);
        send(rnd_cmd(0));
        drain();

        // Randomised traffic.
        ready_pct = 60;
        for (int i = 0; i < 40; i++) begin
            send(rnd_cmd(20));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        chk("err_count_final", err_count, exp_errcnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
